// File: rtl/serializer_pkg.sv
// Shared definitions for the single-wire serial link (transmitter and receiver).
package serializer_pkg;

  // FSM state codes, shared so the receiver and debug tooling agree on encoding.
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = S_IDLE,
    ST_START = S_START,
    ST_DATA  = S_DATA,
    ST_GAP   = S_GAP
  } state_t;

  // Line levels: the start marker is a single high bit; the idle line is low.
  localparam logic START_MARK = 1'b1;
  localparam logic IDLE_LEVEL = 1'b0;

endpackage

// File: rtl/piso_shift_reg.sv
// WIDTH-bit load/shift register; presents the bit currently at the output end.
module piso_shift_reg #(
  parameter int WIDTH     = 6,
  parameter int LSB_FIRST = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] data,
  output logic             out_bit
);

  logic [WIDTH-1:0] q;

  generate
    if (LSB_FIRST != 0) begin : g_lsb
      // Load a new word, or move the next bit down toward bit 0.
      always_ff @(posedge clock or posedge reset) begin
        if (reset)         q <= '0;
        else if (load)     q <= data;
        else if (shift_en) q <= {1'b0, q[WIDTH-1:1]};
      end
      assign out_bit = q[0];
    end else begin : g_msb
      // Load a new word, or move the next bit up toward bit WIDTH-1.
      always_ff @(posedge clock or posedge reset) begin
        if (reset)         q <= '0;
        else if (load)     q <= data;
        else if (shift_en) q <= {q[WIDTH-2:0], 1'b0};
      end
      assign out_bit = q[WIDTH-1];
    end
  endgenerate

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter: start marker, WIDTH data bits, idle gap.
//
// Handshake: a word is accepted on a rising edge where in_valid and in_ready
// are both high; in_ready is high only in IDLE, in_valid is ignored otherwise
// and nothing is buffered. in_data is sampled only on that accepting edge.
module piso_serializer
  import serializer_pkg::*;
#(
  parameter int WIDTH      = 6,
  parameter int LSB_FIRST  = 0,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             so,
  output logic             frame,
  output logic             busy,
  output logic             done,
  output logic [1:0]       fsm_state
);

  localparam int CW = $clog2(WIDTH);
  // A zero-cycle gap never enters GAP; keep the counter one bit wide so it exists.
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  state_t          state;
  logic [CW-1:0]   bit_cnt;
  logic [GW-1:0]   gap_cnt;
  logic            accept;
  logic            sr_bit;

  assign accept = in_valid & (state == ST_IDLE);

  piso_shift_reg #(
    .WIDTH     (WIDTH),
    .LSB_FIRST (LSB_FIRST)
  ) u_shift (
    .clock    (clock),
    .reset    (reset),
    .load     (accept),
    .shift_en (state == ST_DATA),
    .data     (in_data),
    .out_bit  (sr_bit)
  );

  // Frame sequencer with bit/gap counters and the registered done pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      gap_cnt <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) state <= ST_START;
        end
        ST_START: begin
          bit_cnt <= '0;
          state   <= ST_DATA;
        end
        ST_DATA: begin
          if (bit_cnt == BIT_LAST) begin
            done    <= 1'b1;
            bit_cnt <= '0;
            gap_cnt <= '0;
            state   <= (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) state <= ST_IDLE;
          else                     gap_cnt <= gap_cnt + 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Line level decoded from the registered state and the shift register.
  always_comb begin
    so = IDLE_LEVEL;
    case (state)
      ST_START: so = START_MARK;
      ST_DATA:  so = sr_bit;
      default:  so = IDLE_LEVEL;
    endcase
  end

  assign frame     = (state == ST_DATA);
  assign busy      = (state != ST_IDLE);
  assign in_ready  = (state == ST_IDLE);
  assign fsm_state = state;

endmodule
